rvvi_retire_tracer: RTL and testbench

RVVI_RETIRE_TRACER -- requirements
Module: rvvi_retire_tracer

---
 rtl/rvvi_pkg.sv | 36 +++
 rtl/rvvi_retire_tracer.sv | 152 +++++++++++++++
 tb/tb_rvvi_retire_tracer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvvi_pkg.sv
// Shared types and constants for the RVVI retire tracer.
package rvvi_pkg;

    localparam int unsigned MAX_XLEN = 64;
    localparam int unsigned MAX_ILEN = 64;

    localparam logic [1:0] IXL_32 = 2'b01;
    localparam logic [1:0] IXL_64 = 2'b10;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HELD   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // One captured retire event, stored at maximum width and narrowed on use.
    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [MAX_ILEN-1:0] insn;
        logic                trap;
        logic [1:0]          mode;
        logic                rd_we;
        logic [4:0]          rd_addr;
        logic [MAX_XLEN-1:0] rd_data;
        logic                csr_we;
        logic [11:0]         csr_addr;
        logic [MAX_XLEN-1:0] csr_data;
    } hold_t;

    // Fall-through PC: 4 for a full-length encoding, 2 for a compressed one.
    function automatic logic [MAX_XLEN-1:0] next_pc(input logic [MAX_XLEN-1:0] pc,
                                                    input logic [1:0]          insn_lo);
        return pc + ((insn_lo == 2'b11) ? MAX_XLEN'(4) : MAX_XLEN'(2));
    endfunction

endpackage

// File: rtl/rvvi_retire_tracer.sv
// Converts a core retire stream into RVVI trace records, delaying each
// instruction by one retire so that its pc_wdata is the next retired PC.
module rvvi_retire_tracer
    import rvvi_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ret_valid,
    input  logic [XLEN-1:0]            ret_pc,
    input  logic [ILEN-1:0]            ret_insn,
    input  logic                       ret_trap,
    input  logic [1:0]                 ret_mode,
    input  logic                       ret_rd_we,
    input  logic [4:0]                 ret_rd_addr,
    input  logic [XLEN-1:0]            ret_rd_data,
    input  logic                       ret_csr_we,
    input  logic [11:0]                ret_csr_addr,
    input  logic [XLEN-1:0]            ret_csr_data,
    input  logic                       halt_req,
    output logic                       valid,
    output logic [63:0]                order,
    output logic [ILEN-1:0]            insn,
    output logic                       trap,
    output logic                       halt,
    output logic [1:0]                 mode,
    output logic [1:0]                 ixl,
    output logic [XLEN-1:0]            pc_rdata,
    output logic [XLEN-1:0]            pc_wdata,
    output logic [31:0][XLEN-1:0]      x_wdata,
    output logic [31:0]                x_wb,
    output logic                       csr_wb,
    output logic [11:0]                csr_addr,
    output logic [XLEN-1:0]            csr_wdata
);

    localparam logic [1:0] IXL = (XLEN == 64) ? IXL_64 : IXL_32;

    state_e          state_q, state_d;
    hold_t           hold_q, hold_d;
    hold_t           cap;
    logic            pend_q, pend_d;
    logic            emit;
    logic            flush;
    logic            gpr_we;
    logic            csr_rep;
    logic [XLEN-1:0] pc_next;

    // Next-state logic: capture, emit-and-recapture, or flush the hold entry.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        emit    = 1'b0;
        flush   = 1'b0;
        cap     = '{
            pc:       MAX_XLEN'(ret_pc),
            insn:     MAX_ILEN'(ret_insn),
            trap:     ret_trap,
            mode:     ret_mode,
            rd_we:    ret_rd_we,
            rd_addr:  ret_rd_addr,
            rd_data:  MAX_XLEN'(ret_rd_data),
            csr_we:   ret_csr_we,
            csr_addr: ret_csr_addr,
            csr_data: MAX_XLEN'(ret_csr_data)
        };
        case (state_q)
            ST_EMPTY: begin
                if (ret_valid) begin
                    hold_d  = cap;
                    pend_d  = halt_req;
                    state_d = ST_HELD;
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HELD: begin
                if (pend_q) begin
                    // Deferred halt wins over anything presented this cycle.
                    emit    = 1'b1;
                    flush   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = ST_HALTED;
                end else if (ret_valid) begin
                    emit   = 1'b1;
                    hold_d = cap;
                    pend_d = halt_req;
                end else if (halt_req) begin
                    emit    = 1'b1;
                    flush   = 1'b1;
                    state_d = ST_HALTED;
                end
            end
            default: begin
            end
        endcase
        pc_next = flush ? XLEN'(next_pc(hold_q.pc, hold_q.insn[1:0])) : ret_pc;
        gpr_we  = emit && hold_q.rd_we && !hold_q.trap && (hold_q.rd_addr != 5'd0);
        csr_rep = emit && hold_q.csr_we && !hold_q.trap;
    end

    // State, hold entry, shadow GPRs and registered RVVI outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            hold_q    <= '0;
            pend_q    <= 1'b0;
            valid     <= 1'b0;
            order     <= 64'd0;
            insn      <= '0;
            trap      <= 1'b0;
            halt      <= 1'b0;
            mode      <= 2'b00;
            ixl       <= IXL;
            pc_rdata  <= '0;
            pc_wdata  <= '0;
            x_wdata   <= '0;
            x_wb      <= 32'd0;
            csr_wb    <= 1'b0;
            csr_addr  <= 12'd0;
            csr_wdata <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            valid   <= emit;
            halt    <= flush;
            ixl     <= IXL;
            x_wb    <= 32'd0;
            csr_wb  <= 1'b0;
            if (emit) begin
                order     <= order + 64'd1;
                insn      <= ILEN'(hold_q.insn);
                trap      <= hold_q.trap;
                mode      <= hold_q.mode;
                pc_rdata  <= XLEN'(hold_q.pc);
                pc_wdata  <= pc_next;
                x_wb      <= gpr_we ? (32'b1 << hold_q.rd_addr) : 32'd0;
                csr_wb    <= csr_rep;
                csr_addr  <= hold_q.csr_addr;
                csr_wdata <= XLEN'(hold_q.csr_data);
                if (gpr_we) begin
                    x_wdata[hold_q.rd_addr] <= XLEN'(hold_q.rd_data);
                end
            end
        end
    end

endmodule

// File: tb/tb_rvvi_retire_tracer.sv
// Directed bench for rvvi_retire_tracer with a behavioural scoreboard.
module tb_rvvi_retire_tracer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic [1:0]  mode;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_data;
    } ev_t;

    typedef struct {
        logic [63:0] order;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic [1:0]  mode;
        logic [31:0] x_wb;
        logic        csr_wb;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              ret_valid;
    logic [31:0]       ret_pc;
    logic [31:0]       ret_insn;
    logic              ret_trap;
    logic [1:0]        ret_mode;
    logic              ret_rd_we;
    logic [4:0]        ret_rd_addr;
    logic [31:0]       ret_rd_data;
    logic              ret_csr_we;
    logic [11:0]       ret_csr_addr;
    logic [31:0]       ret_csr_data;
    logic              halt_req;
    logic              valid;
    logic [63:0]       order;
    logic [31:0]       insn;
    logic              trap;
    logic              halt;
    logic [1:0]        mode;
    logic [1:0]        ixl;
    logic [31:0]       pc_rdata;
    logic [31:0]       pc_wdata;
    logic [31:0][31:0] x_wdata;
    logic [31:0]       x_wb;
    logic              csr_wb;
    logic [11:0]       csr_addr;
    logic [31:0]       csr_wdata;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          mstate;  // 0 empty, 1 held, 2 halted
    ev_t         mhold;
    logic        mpend;
    logic [63:0] morder;
    logic [31:0] mgpr [32];
    exp_t        sb [$];

    rvvi_retire_tracer #(.XLEN(32), .ILEN(32)) dut (
        .clk(clk), .reset(reset),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_insn(ret_insn),
        .ret_trap(ret_trap), .ret_mode(ret_mode), .ret_rd_we(ret_rd_we),
        .ret_rd_addr(ret_rd_addr), .ret_rd_data(ret_rd_data),
        .ret_csr_we(ret_csr_we), .ret_csr_addr(ret_csr_addr),
        .ret_csr_data(ret_csr_data), .halt_req(halt_req),
        .valid(valid), .order(order), .insn(insn), .trap(trap), .halt(halt),
        .mode(mode), .ixl(ixl), .pc_rdata(pc_rdata), .pc_wdata(pc_wdata),
        .x_wdata(x_wdata), .x_wb(x_wb), .csr_wb(csr_wb),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t ev(input logic [31:0] pc, input logic [31:0] ins,
                               input logic we, input logic [4:0] rd, input logic [31:0] d);
        ev_t e;
        e.pc = pc; e.insn = ins; e.trap = 1'b0; e.mode = 2'b11;
        e.rd_we = we; e.rd = rd; e.rd_data = d;
        e.csr_we = 1'b0; e.csr_addr = 12'h0; e.csr_data = 32'h0;
        return e;
    endfunction

    task automatic push_emit(input logic is_flush, input logic [31:0] pcw);
        exp_t x;
        logic wb;
        morder++;
        wb = mhold.rd_we && !mhold.trap && (mhold.rd != 5'd0);
        x.order     = morder;
        x.pc_rdata  = mhold.pc;
        x.pc_wdata  = pcw;
        x.insn      = mhold.insn;
        x.trap      = mhold.trap;
        x.halt      = is_flush;
        x.mode      = mhold.mode;
        x.x_wb      = wb ? (32'h1 << mhold.rd) : 32'h0;
        x.csr_wb    = mhold.csr_we && !mhold.trap;
        x.csr_addr  = mhold.csr_addr;
        x.csr_wdata = mhold.csr_data;
        if (wb) mgpr[mhold.rd] = mhold.rd_data;
        sb.push_back(x);
    endtask

    task automatic model(input logic rst, input logic rv, input logic hreq, input ev_t e);
        logic [31:0] fpc;
        if (rst) begin
            mstate = 0; mpend = 1'b0; morder = 64'd0;
            foreach (mgpr[i]) mgpr[i] = 32'h0;
            sb.delete();
        end else begin
            fpc = mhold.pc + ((mhold.insn[1:0] == 2'b11) ? 32'd4 : 32'd2);
            case (mstate)
                0: begin
                    if (rv) begin mhold = e; mpend = hreq; mstate = 1; end
                    else if (hreq) mstate = 2;
                end
                1: begin
                    if (mpend) begin push_emit(1'b1, fpc); mpend = 1'b0; mstate = 2; end
                    else if (rv) begin push_emit(1'b0, e.pc); mhold = e; mpend = hreq; end
                    else if (hreq) begin push_emit(1'b1, fpc); mstate = 2; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("valid", 64'(valid), 64'd1);
            chk("order", order, x.order);
            chk("pc_rdata", 64'(pc_rdata), 64'(x.pc_rdata));
            chk("pc_wdata", 64'(pc_wdata), 64'(x.pc_wdata));
            chk("insn", 64'(insn), 64'(x.insn));
            chk("trap", 64'(trap), 64'(x.trap));
            chk("halt", 64'(halt), 64'(x.halt));
            chk("mode", 64'(mode), 64'(x.mode));
            chk("x_wb", 64'(x_wb), 64'(x.x_wb));
            chk("csr_wb", 64'(csr_wb), 64'(x.csr_wb));
            if (x.csr_wb) begin
                chk("csr_addr", 64'(csr_addr), 64'(x.csr_addr));
                chk("csr_wdata", 64'(csr_wdata), 64'(x.csr_wdata));
            end
        end else begin
            chk("idle_valid", 64'(valid), 64'd0);
            chk("idle_x_wb", 64'(x_wb), 64'd0);
            chk("idle_csr_wb", 64'(csr_wb), 64'd0);
        end
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("x_wdata[%0d]", i), 64'(x_wdata[i]), 64'(mgpr[i]));
        end
        chk("ixl", 64'(ixl), 64'd1);
    endtask

    task automatic drive(input logic rst, input logic rv, input logic hreq, input ev_t e);
        reset        = rst;
        ret_valid    = rv;
        ret_pc       = e.pc;
        ret_insn     = e.insn;
        ret_trap     = e.trap;
        ret_mode     = e.mode;
        ret_rd_we    = e.rd_we;
        ret_rd_addr  = e.rd;
        ret_rd_data  = e.rd_data;
        ret_csr_we   = e.csr_we;
        ret_csr_addr = e.csr_addr;
        ret_csr_data = e.csr_data;
        halt_req     = hreq;
        model(rst, rv, hreq, e);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        ev_t z, e;
        z = ev(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        mstate = 0; mpend = 1'b0; morder = 64'd0; mhold = z;
        foreach (mgpr[i]) mgpr[i] = 32'h0;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, z);
        drive(1'b1, 1'b0, 1'b0, z);
        chk("rst_order", order, 64'd0);
        chk("rst_pc_wdata", 64'(pc_wdata), 64'd0);

        // Basic retire pair
        drive(1'b0, 1'b1, 1'b0, ev(32'h100, 32'h00500093, 1'b1, 5'd1, 32'd5));
        drive(1'b0, 1'b1, 1'b0, ev(32'h104, 32'h00000013, 1'b0, 5'd0, 32'd0));
        chk("s1_order", order, 64'd1);
        chk("s1_pc_rdata", 64'(pc_rdata), 64'h100);
        chk("s1_pc_wdata", 64'(pc_wdata), 64'h104);
        chk("s1_x_wb", 64'(x_wb), 64'h2);
        chk("s1_x1", 64'(x_wdata[1]), 64'd5);
        drive(1'b0, 1'b0, 1'b0, z);

        // Trapped write is discarded
        e = ev(32'h300, 32'h0ff00193, 1'b1, 5'd3, 32'hFF);
        e.trap = 1'b1;
        drive(1'b0, 1'b1, 1'b0, e);
        drive(1'b0, 1'b1, 1'b0, ev(32'h304, 32'h00000013, 1'b1, 5'd0, 32'hDEAD));
        chk("trap_flag", 64'(trap), 64'd1);
        chk("trap_x_wb", 64'(x_wb), 64'd0);
        chk("trap_x3", 64'(x_wdata[3]), 64'd0);

        // Write to x0 plus a CSR-reporting instruction
        e = ev(32'h308, 32'h30529073, 1'b1, 5'd5, 32'd7);
        e.csr_we = 1'b1; e.csr_addr = 12'h305; e.csr_data = 32'h1888;
        drive(1'b0, 1'b1, 1'b0, e);
        chk("x0_x_wb", 64'(x_wb), 64'd0);
        chk("x0_value", 64'(x_wdata[0]), 64'd0);

        // Retire and halt together, then deferred flush overrides a new retire
        drive(1'b0, 1'b1, 1'b1, ev(32'h30c, 32'h00000013, 1'b0, 5'd0, 32'd0));
        chk("both_order", order, 64'd5);
        chk("both_csr_wb", 64'(csr_wb), 64'd1);
        chk("both_halt", 64'(halt), 64'd0);
        drive(1'b0, 1'b1, 1'b0, ev(32'h400, 32'h00000013, 1'b1, 5'd6, 32'd9));
        chk("pend_order", order, 64'd6);
        chk("pend_halt", 64'(halt), 64'd1);
        chk("pend_pc_wdata", 64'(pc_wdata), 64'h310);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, i[0], ev(32'h500 + 32'(i * 4), 32'h00100093, 1'b1, 5'd1, 32'd3));
        end

        // Reset while holding an entry discards it
        drive(1'b1, 1'b0, 1'b0, z);
        drive(1'b0, 1'b1, 1'b0, ev(32'h500, 32'h00900113, 1'b1, 5'd2, 32'd9));
        drive(1'b1, 1'b1, 1'b0, ev(32'h504, 32'h00000013, 1'b0, 5'd0, 32'd0));
        drive(1'b0, 1'b0, 1'b0, z);
        drive(1'b0, 1'b1, 1'b0, ev(32'h600, 32'h00300213, 1'b1, 5'd4, 32'd3));
        drive(1'b0, 1'b1, 1'b0, ev(32'h200, 32'h00004505, 1'b1, 5'd10, 32'd1));
        chk("rst_held_order", order, 64'd1);
        chk("rst_held_x2", 64'(x_wdata[2]), 64'd0);

        // Compressed instruction flushed by a halt
        drive(1'b0, 1'b0, 1'b1, z);
        chk("halt_c_valid", 64'(valid), 64'd1);
        chk("halt_c_halt", 64'(halt), 64'd1);
        chk("halt_c_pc_wdata", 64'(pc_wdata), 64'h202);
        chk("halt_c_x10", 64'(x_wdata[10]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, ev(32'h700 + 32'(i * 4), 32'h00000013, 1'b1, 5'd7, 32'd1));
        end

        // Halt straight from EMPTY: nothing is ever emitted
        drive(1'b1, 1'b0, 1'b0, z);
        drive(1'b0, 1'b0, 1'b1, z);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, ev(32'h800 + 32'(i * 4), 32'h00100093, 1'b1, 5'd1, 32'd2));
        end
        chk("empty_halt_order", order, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
